// File: rtl/y86_bus_pkg.sv
// Shared definitions for the y86 bus bridge: IO map, error bits, TX status layout, region decode.
package y86_bus_pkg;

    localparam logic [3:0] TX_OFS  = 4'h0;
    localparam logic [3:0] CYC_OFS = 4'h4;
    localparam logic [3:0] ERR_OFS = 4'h8;

    localparam int unsigned ERR_W         = 3;
    localparam int unsigned ERR_UNMAPPED  = 0;
    localparam int unsigned ERR_OVERFLOW  = 1;
    localparam int unsigned ERR_UNALIGNED = 2;

    typedef struct packed {
        logic [21:0] rsvd;
        logic        full;
        logic        empty;
        logic [7:0]  count;
    } tx_status_t;

    typedef enum logic [1:0] {REG_RAM, REG_IO, REG_UNMAPPED} region_e;

    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] io_base);
        if (addr < ram_bytes)
            return REG_RAM;
        if (addr[31:4] == io_base[31:4])
            return REG_IO;
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/y86_bus_bridge_tx_fifo.sv
// Transmit FIFO with valid/ready head output; reset empties it asynchronously.
module y86_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     push_dropped
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;
    logic             push_ok;

    assign empty        = (count == '0);
    assign full         = (count == (PW+1)'(DEPTH));
    assign valid        = !empty;
    assign pop          = valid && pop_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok      = push && (!full || pop);
    assign push_dropped = push && full && !pop;
    assign head         = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/y86_bus_bridge.sv
// Memory/MMIO responder for the y86 core bus: byte RAM, TX FIFO, cycle counter and sticky errors.
module y86_bus_bridge
    import y86_bus_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  bus_A,
    input  logic [31:0]                  bus_out,
    input  logic                         bus_RE,
    input  logic                         bus_WE,
    output logic [31:0]                  bus_in,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
    input  logic [7:0]                   prog_data,
    output logic                         err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       mem [MEM_BYTES];
    logic [AW-1:0]    idx [4];
    region_e          region;
    logic [3:0]       ofs;
    logic             io_access;
    logic             ram_we;
    logic             tx_push;
    logic             cyc_load;
    logic             err_wr;
    logic [31:0]      cycles;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_set;
    logic [ERR_W-1:0] err_clr;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_dropped;
    tx_status_t       tx_status;

    assign region    = decode_region(bus_A, 32'(MEM_BYTES), IO_BASE);
    // Unaligned IO accesses are served from the enclosing word.
    assign ofs       = {bus_A[3:2], 2'b00};
    assign io_access = (region == REG_IO) && (bus_RE || bus_WE);
    assign ram_we    = (region == REG_RAM) && bus_WE;
    assign tx_push   = (region == REG_IO) && bus_WE && (ofs == TX_OFS);
    assign cyc_load  = (region == REG_IO) && bus_WE && (ofs == CYC_OFS);
    assign err_wr    = (region == REG_IO) && bus_WE && (ofs == ERR_OFS);

    always_comb begin
        for (int k = 0; k < 4; k++)
            idx[k] = bus_A[AW-1:0] + AW'(k);
    end

    y86_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (tx_push),
        .push_data    (bus_out[7:0]),
        .pop_ready    (tx_ready),
        .head         (tx_data),
        .valid        (tx_valid),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .push_dropped (push_dropped)
    );

    always_comb begin
        tx_status       = '0;
        tx_status.full  = fifo_full;
        tx_status.empty = fifo_empty;
        tx_status.count = 8'(fifo_count);
    end

    // Combinational read path; the core samples bus_in in the cycle it drives bus_A.
    always_comb begin
        bus_in = '0;
        if (bus_RE) begin
            case (region)
                REG_RAM: bus_in = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
                REG_IO: begin
                    case (ofs)
                        TX_OFS:  bus_in = tx_status;
                        CYC_OFS: bus_in = cycles;
                        ERR_OFS: bus_in = 32'(err_q);
                        default: bus_in = '0;
                    endcase
                end
                default: bus_in = '0;
            endcase
        end
    end

    // Program-load byte is written last so it wins over a core store to the same byte.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++)
                mem[idx[k]] <= bus_out[8*k +: 8];
        end
        if (prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycles <= '0;
        else if (cyc_load)
            cycles <= bus_out;
        else
            cycles <= cycles + 32'd1;
    end

    always_comb begin
        err_set                = '0;
        err_set[ERR_UNMAPPED]  = (region == REG_UNMAPPED) && (bus_RE || bus_WE);
        err_set[ERR_OVERFLOW]  = push_dropped;
        err_set[ERR_UNALIGNED] = io_access && (bus_A[1:0] != 2'b00);
        err_clr                = err_wr ? bus_out[ERR_W-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else
            err_q <= (err_q & ~err_clr) | err_set;
    end

    assign err = |err_q;

endmodule

// File: tb/tb_y86_bus_bridge.sv
// Self-checking bench for y86_bus_bridge: vector table plus FIFO/reset sequences with a TX scoreboard.
module tb_y86_bus_bridge;

    localparam int unsigned MEM_BYTES = 1024;
    localparam logic [31:0] IO        = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic [31:0] bus_A;
    logic [31:0] bus_out;
    logic        bus_RE;
    logic        bus_WE;
    logic [31:0] bus_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        err;

    int tests;
    int fails;

    typedef struct {
        string       name;
        logic        re;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        pwe;
        logic [9:0]  pa;
        logic [7:0]  pd;
        logic [31:0] exp_in;
        logic        exp_err;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    y86_bus_bridge #(.MEM_BYTES(MEM_BYTES), .FIFO_DEPTH(8), .IO_BASE(IO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_A     (bus_A),
        .bus_out   (bus_out),
        .bus_RE    (bus_RE),
        .bus_WE    (bus_WE),
        .bus_in    (bus_in),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_RE  = 1'b0;
        bus_WE  = 1'b0;
        bus_A   = '0;
        bus_out = '0;
        prog_we = 1'b0;
    endtask

    task automatic prog(input logic [9:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        bus_WE  = 1'b1;
        bus_A   = IO;
        bus_out = 32'(b);
        step();
        idle();
    endtask

    task automatic add(input string n, input logic re, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic pwe, input logic [9:0] pa,
                       input logic [7:0] pd, input logic [31:0] exp_in, input logic exp_err);
        vec_t v;
        v.name = n; v.re = re; v.we = we; v.a = a; v.d = d;
        v.pwe = pwe; v.pa = pa; v.pd = pd; v.exp_in = exp_in; v.exp_err = exp_err;
        vq.push_back(v);
    endtask

    // Scoreboard: every handshake seen before the pop edge must match the oldest pushed byte.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_pop: got %h expected no byte", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check32("tx_pop", 32'(tx_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        tx_ready = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        idle();

        add("ram_read",      1, 0, 32'h0,        32'h0,          0, 10'h0,  8'h0,  32'h4433_2211, 0);
        add("ram_wrap_read", 1, 0, 32'd1022,     32'h0,          0, 10'h0,  8'h0,  32'h2211_BBAA, 0);
        add("store_old",     1, 1, 32'h10,       32'hDEAD_BEEF,  0, 10'h0,  8'h0,  32'h0403_0201, 0);
        add("store_new",     1, 0, 32'h10,       32'h0,          0, 10'h0,  8'h0,  32'hDEAD_BEEF, 0);
        add("prog_prio_wr",  0, 1, 32'h20,       32'hAABB_CCDD,  1, 10'h20, 8'h55, 32'h0,         0);
        add("prog_prio_rd",  1, 0, 32'h20,       32'h0,          0, 10'h0,  8'h0,  32'hAABB_CC55, 0);
        add("wrap_write",    0, 1, 32'd1022,     32'h1234_5678,  0, 10'h0,  8'h0,  32'h0,         0);
        add("wrap_write_rd", 1, 0, 32'h0,        32'h0,          0, 10'h0,  8'h0,  32'h4433_1234, 0);
        add("re_low_zero",   0, 0, 32'h0,        32'h0,          0, 10'h0,  8'h0,  32'h0,         0);
        add("unmapped_rd",   1, 0, 32'h8000,     32'h0,          0, 10'h0,  8'h0,  32'h0,         1);
        add("err_rd_unmap",  1, 0, IO + 32'h8,   32'h0,          0, 10'h0,  8'h0,  32'h1,         1);
        add("err_w1c",       0, 1, IO + 32'h8,   32'h1,          0, 10'h0,  8'h0,  32'h0,         0);
        add("err_rd_clear",  1, 0, IO + 32'h8,   32'h0,          0, 10'h0,  8'h0,  32'h0,         0);
        add("cyc_load",      0, 1, IO + 32'h4,   32'd100,        0, 10'h0,  8'h0,  32'h0,         0);
        add("cyc_read",      1, 0, IO + 32'h4,   32'h0,          0, 10'h0,  8'h0,  32'd100,       0);
        add("cyc_unaligned", 1, 0, IO + 32'h5,   32'h0,          0, 10'h0,  8'h0,  32'd101,       1);
        add("err_rd_unal",   1, 0, IO + 32'h8,   32'h0,          0, 10'h0,  8'h0,  32'h4,         1);
        add("err_w1c_all",   0, 1, IO + 32'h8,   32'hFFFF_FFFF,  0, 10'h0,  8'h0,  32'h0,         0);
        add("rsvd_read",     1, 0, IO + 32'hC,   32'h0,          0, 10'h0,  8'h0,  32'h0,         0);
        add("rsvd_write",    0, 1, IO + 32'hC,   32'h5,          0, 10'h0,  8'h0,  32'h0,         0);
        add("tx_stat_empty", 1, 0, IO,           32'h0,          0, 10'h0,  8'h0,  32'h100,       0);

        #3;
        check32("rst_tx_valid", 32'(tx_valid), 32'h0);
        check32("rst_tx_data",  32'(tx_data),  32'h0);
        check32("rst_err",      32'(err),      32'h0);
        check32("rst_bus_in",   bus_in,        32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        prog(10'd0, 8'h11);    prog(10'd1, 8'h22);
        prog(10'd2, 8'h33);    prog(10'd3, 8'h44);
        prog(10'd1022, 8'hAA); prog(10'd1023, 8'hBB);
        prog(10'h10, 8'h01);   prog(10'h11, 8'h02);
        prog(10'h12, 8'h03);   prog(10'h13, 8'h04);

        foreach (vq[i]) begin
            bus_RE = vq[i].re; bus_WE = vq[i].we; bus_A = vq[i].a; bus_out = vq[i].d;
            prog_we = vq[i].pwe; prog_addr = vq[i].pa; prog_data = vq[i].pd;
            #1;
            check32({vq[i].name, "_data"}, bus_in, vq[i].exp_in);
            @(posedge clk);
            #1;
            check32({vq[i].name, "_err"}, 32'(err), 32'(vq[i].exp_err));
            idle();
        end

        // Fill to full, overflow once, then drain with ready held high.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h41 + 8'(i));
            tx_write(8'h41 + 8'(i));
        end
        bus_RE = 1'b1; bus_A = IO;
        #1;
        check32("tx_stat_full", bus_in, 32'h208);
        check32("tx_head_full", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h41});
        step();
        idle();
        tx_write(8'h49);
        check32("ovf_err_flag", 32'(err), 32'h1);
        bus_RE = 1'b1; bus_A = IO + 32'h8;
        #1;
        check32("ovf_err_reg", bus_in, 32'h2);
        step();
        idle();
        bus_WE = 1'b1; bus_A = IO + 32'h8; bus_out = 32'h2;
        step();
        idle();
        check32("ovf_err_clr", 32'(err), 32'h0);
        tx_ready = 1'b1;
        repeat (7) step();
        check32("drain_last", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h48});
        step();
        check32("drain_valid", 32'(tx_valid), 32'h0);
        check32("drain_sb", 32'(exp_q.size()), 32'h0);
        tx_ready = 1'b0;

        // Push into a full FIFO in the same cycle as a pop.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            tx_write(8'h61 + 8'(i));
        end
        exp_q.push_back(8'h70);
        tx_ready = 1'b1;
        tx_write(8'h70);
        tx_ready = 1'b0;
        bus_RE = 1'b1; bus_A = IO;
        #1;
        check32("pushpop_stat", bus_in, 32'h208);
        check32("pushpop_err", 32'(err), 32'h0);
        step();
        idle();
        tx_ready = 1'b1;
        repeat (8) step();
        check32("pushpop_valid", 32'(tx_valid), 32'h0);
        check32("pushpop_sb", 32'(exp_q.size()), 32'h0);
        tx_ready = 1'b0;

        // Asynchronous reset with bytes queued.
        tx_write(8'h31);
        tx_write(8'h32);
        tx_write(8'h33);
        check32("pre_rst_valid", 32'(tx_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check32("async_rst_valid", 32'(tx_valid), 32'h0);
        check32("async_rst_data",  32'(tx_data),  32'h0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_RE = 1'b1; bus_A = IO + 32'h4;
        #1;
        check32("post_rst_cycles", bus_in, 32'h0);
        step();
        bus_A = IO;
        #1;
        check32("post_rst_stat", bus_in, 32'h100);
        check32("post_rst_err", 32'(err), 32'h0);
        step();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
